nibble_serial_addsub: RTL
=========================

// Module: nibble_serial_addsub
//
// PURPOSE
//   Sequencer that performs a WIDTH-bit add or subtract one 4-bit nibble per cycle, LSB nibble first.
//   Each step uses a 4-bit adder slice with carry-in, plus a 4-bit inverter for subtract.
//   Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
//   Carry is held in a register between steps, so an op takes WIDTH/4 cycles through one narrow adder.
//
// PARAMETERS
//   WIDTH   16   operand/result width; must be a multiple of 4 and >= 4
//   NIB     WIDTH/4 (localparam)   number of RUN steps per operation
//
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a/b/op_sub are valid
//   in_ready   out  1      block can accept an operation (high only in IDLE)
//   op_sub     in   1      0: a+b   1: a-b
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      result/cout/ovf are valid (high only in DONE)
//   out_ready  in   1      consumer accepts the result
//   result     out  WIDTH  sum/difference, modulo 2^WIDTH
//   cout       out  1      carry out of MSB; for subtract, 1 = no borrow
//   ovf        out  1      two's-complement signed overflow
//
// BEHAVIOUR
//   - FSM states: IDLE -> RUN -> DONE -> IDLE.
//     in_ready = (state==IDLE); out_valid = (state==DONE).
//   - Reset (async, rst_n=0), immediate regardless of state:
//     state=IDLE, step count=0, carry=0, result=0, cout=0, ovf=0, out_valid=0, in_ready=1.
//   - IDLE: on an edge with in_valid=1, the op is accepted. The block then:
//     latches A=a and B'=(op_sub ? ~b : b); sets carry=op_sub; clears result; sets count=0; goes to RUN.
//   - IDLE with in_valid=0: no change.
//   - RUN, each edge k=0..NIB-1:
//     {c,s} = A[4k+3:4k] + B'[4k+3:4k] + carry (5-bit);
//     result[4k+3:4k]<=s; carry<=c; count<=count+1.
//   - RUN end: on the edge with k=NIB-1, state<=DONE; cout<=c.
//     ovf <= (A[MSB]==B'[MSB]) && (s[3]!=A[MSB]).
//   - Latency: out_valid rises exactly NIB cycles after the accept edge (WIDTH=16: 4; WIDTH=4: 1).
//   - RUN ignores in_valid and out_ready; no queuing.
//     result is partial during RUN and is not meaningful until out_valid=1.
//   - DONE: result/cout/ovf held stable while out_ready=0, for an unbounded time.
//     On an edge with out_ready=1, state<=IDLE; outputs keep their values until the next accept.
//   - Throughput: one op per NIB+2 cycles minimum.
//     There is no bypass from DONE to accept; in_ready is low in DONE.
//   - Wrap-around: result wraps modulo 2^WIDTH; the MSB carry appears only on cout.
//   - Reset mid-RUN/DONE: the op is discarded and no out_valid is produced for it.
//
// TESTING (WIDTH=16 unless noted)
//   1. Assert rst_n=0 asynchronously mid-cycle -> immediately in_ready=1, out_valid=0, result=0, cout=0, ovf=0.
//   2. add 0x1234+0x0FFF -> result=0x2233, cout=0, ovf=0.
//      out_valid exactly 4 cycles after accept; in_ready=0 from the accept edge until the DONE handshake.
//   3. add 0xFFFF+0x0001 -> result=0x0000, cout=1, ovf=0 (carry ripples through all 4 nibbles);
//      add 0x7FFF+0x0001 -> 0x8000, cout=0, ovf=1.
//   4. sub 0x8000-0x0001 -> result=0x7FFF, cout=1, ovf=1;
//      sub 0x0003-0x0005 -> 0xFFFE, cout=0, ovf=0.
//   5. Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands ->
//      result/cout/ovf unchanged, in_ready=0, new op not taken;
//      out_ready=1 -> IDLE, then the new op is accepted.
//   6. rst_n pulse after 2 RUN steps -> reset values; no out_valid for the aborted op;
//      next op add 0x00FF+0x0001 -> 0x0100 after 4 cycles.
//      Repeat tests 2/3 with WIDTH=4 (0xF+0x1 -> 0x0, cout=1, latency 1).

Source files
------------

// File: rtl/nibble_serial_addsub_if.sv
// Operand/result handshake bundle for the nibble-serial add/sub block.
// The producer/consumer side uses master; the arithmetic block uses slave.
interface nibble_serial_addsub_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, cout, ovf
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract computed one 4-bit nibble per cycle, LSB first,
// through a single 4-bit adder slice with a registered carry between steps.
module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_serial_addsub_if.slave  bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb, res;
  logic             carry, cout_q, ovf_q, in_ready_q, out_valid_q;
  logic [CW-1:0]    cnt;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       sum;
  logic             last;

  // opb already holds ~b for subtract; carry-in of 1 completes the negate.
  assign a_nib = opa[{cnt, 2'b00} +: 4];
  assign b_nib = opb[{cnt, 2'b00} +: 4];
  assign sum   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
  assign last  = (cnt == CW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      opa         <= '0;
      opb         <= '0;
      res         <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          opa        <= bus.a;
          opb        <= bus.op_sub ? ~bus.b : bus.b;
          carry      <= bus.op_sub;
          res        <= '0;
          cnt        <= '0;
          in_ready_q <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          res[{cnt, 2'b00} +: 4] <= sum[3:0];
          carry                  <= sum[4];
          cnt                    <= cnt + 1'b1;
          if (last) begin
            // Signed overflow: like-signed operands producing an unlike-signed MSB.
            cout_q      <= sum[4];
            ovf_q       <= (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[3] != opa[WIDTH-1]);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
